// File: rtl/flop_chain_pkg.sv
// Shared definitions for the flop-chain PRBS7 checker and its pattern generator.
//   PRBS7 polynomial x^7+x^6+1. History bit 0 is the newest bit, so the next
//   bit is hist[TAP_A] ^ hist[TAP_B].
package flop_chain_pkg;

  localparam int PRBS7_TAP_A = 6;
  localparam int PRBS7_TAP_B = 5;
  localparam int PRBS7_LEN   = 7;

  // Tap mask lets the predictor reduce over the whole history word.
  localparam logic [PRBS7_LEN-1:0] PRBS7_MASK =
    (PRBS7_LEN'(1) << PRBS7_TAP_A) | (PRBS7_LEN'(1) << PRBS7_TAP_B);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } chk_state_t;

endpackage

// File: rtl/prbs7_predict.sv
// Combinational PRBS7 next-bit predictor.
//   hist : 7-bit bit history, hist[0] newest
//   pred : predicted next bit of the sequence
module prbs7_predict
  import flop_chain_pkg::*;
(
  input  logic [PRBS7_LEN-1:0] hist,
  output logic                 pred
);

  assign pred = ^(hist & PRBS7_MASK);

endmodule

// File: rtl/flop_chain_prbs_checker.sv
// Receive-end PRBS7 checker for serial flop-to-flop test pipelines.
// Self-synchronises to the stream at din (HUNT -> SYNC -> LOCK), then runs a
// local LFSR and reports mispredictions.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   en        : din valid; low freezes state/counters, err_pulse goes low
//   din       : serial bit from pipeline tail
//   clr_cnt   : synchronous clear of err_count, wins over increment
//   locked    : high while in LOCK
//   err_pulse : one-cycle pulse per mispredicted bit while locked
//   err_count : saturating error count
//   state_o   : FSM state (0 HUNT, 1 SYNC, 2 LOCK)
module flop_chain_prbs_checker
  import flop_chain_pkg::*;
#(
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state_o
);

  chk_state_t               state, state_nxt;
  logic [PRBS7_LEN-1:0]     shreg;
  logic [2:0]               fill;
  logic [7:0]               run;
  logic [7:0]               miss;

  logic                     pred;
  logic                     match;
  logic [PRBS7_LEN-1:0]     shreg_din;
  logic                     fill_done;
  logic                     run_done;
  logic                     miss_done;
  logic                     lock_err;

  prbs7_predict u_pred (
    .hist (shreg),
    .pred (pred)
  );

  assign match     = (din == pred);
  assign shreg_din = {shreg[PRBS7_LEN-2:0], din};
  assign fill_done = (fill == 3'(PRBS7_LEN - 1));
  assign run_done  = (run  == 8'(LOCK_CNT - 1));
  assign miss_done = (miss == 8'(LOSS_CNT - 1));
  assign lock_err  = en && (state == LOCK) && !match;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      HUNT: if (en && fill_done && (shreg_din != '0)) state_nxt = SYNC;
      SYNC: begin
        if (en) begin
          if (!match)       state_nxt = HUNT;
          else if (run_done) state_nxt = LOCK;
        end
      end
      LOCK: if (lock_err && miss_done) state_nxt = HUNT;
      default: state_nxt = HUNT;   // 2'd3 recovers
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    locked  = (state == LOCK);
    state_o = state;
  end

  // Datapath: history, fill/run/miss counters, error reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      fill      <= '0;
      run       <= '0;
      miss      <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= lock_err;
      if (en) begin
        // In LOCK the history free-runs so a bad bit never corrupts it.
        shreg <= (state == LOCK) ? {shreg[PRBS7_LEN-2:0], pred} : shreg_din;
        // fill only counts in HUNT; any entry into HUNT sees it at zero.
        if (state == HUNT) fill <= fill_done ? 3'd0 : fill + 3'd1;
        else               fill <= 3'd0;
        if (state == SYNC && match && !run_done) run <= run + 8'd1;
        else                                     run <= 8'd0;
        if (state == LOCK && !match && !miss_done) miss <= miss + 8'd1;
        else                                       miss <= 8'd0;
        if (clr_cnt)                          err_count <= '0;
        else if (lock_err && err_count != '1) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flop_chain_prbs_checker.sv
module tb_flop_chain_prbs_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        din;
  logic        clr_cnt = 1'b0;
  logic        chain_en = 1'b0;
  logic        flip = 1'b0;
  logic        zero_mode = 1'b0;

  logic        locked, err_pulse, locked4, err_pulse4;
  logic [15:0] err_count;
  logic [3:0]  err_count4;
  logic [1:0]  state_o, state_o4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flop_chain_prbs_checker #(.LOCK_CNT(8), .LOSS_CNT(4), .ERR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .state_o(state_o)
  );

  flop_chain_prbs_checker #(.LOCK_CNT(8), .LOSS_CNT(4), .ERR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr_cnt(clr_cnt),
    .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4), .state_o(state_o4)
  );

  // PRBS7 generator seeded 7'h7F feeding a 3-flop chain; fm tracks injected flips.
  logic [6:0] g;
  logic [2:0] c, fm;
  logic       gbit;
  assign gbit = g[6] ^ g[5];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g <= 7'h7F; c <= '0; fm <= '0;
    end else if (chain_en) begin
      g  <= {g[5:0], gbit};
      c  <= {c[1:0], gbit ^ flip};
      fm <= {fm[1:0], flip};
    end
  end
  assign din = zero_mode ? 1'b0 : c[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference model
  typedef struct packed {
    logic [1:0]  st;
    logic        lk;
    logic        pl;
    logic [15:0] c16;
    logic [3:0]  c4;
  } exp_t;
  exp_t sb[$];

  int         m_st, m_fill, m_run, m_miss, m_c16, m_c4;
  logic [6:0] m_h;
  logic       m_pl;

  task automatic model_reset();
    m_st = 0; m_fill = 0; m_run = 0; m_miss = 0; m_c16 = 0; m_c4 = 0;
    m_h = '0; m_pl = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic d, input logic clr);
    logic p, bad;
    bad = 1'b0;
    if (!e) begin
      m_pl = 1'b0;
      return;
    end
    p = m_h[6] ^ m_h[5];
    if (m_st == 0) begin
      m_h = {m_h[5:0], d};
      m_fill++;
      if (m_fill == 7) begin
        m_fill = 0;
        if (m_h != 0) begin m_st = 1; m_run = 0; end
      end
    end else if (m_st == 1) begin
      m_h = {m_h[5:0], d};
      if (d == p) begin
        m_run++;
        if (m_run == 8) begin m_st = 2; m_run = 0; m_miss = 0; end
      end else begin
        m_st = 0; m_fill = 0; m_run = 0;
      end
    end else begin
      m_h = {m_h[5:0], p};
      if (d != p) begin
        bad = 1'b1;
        m_miss++;
        if (m_miss == 4) begin m_st = 0; m_fill = 0; m_miss = 0; end
      end else m_miss = 0;
    end
    m_pl = bad;
    if (clr) begin m_c16 = 0; m_c4 = 0; end
    else if (bad) begin
      if (m_c16 < 65535) m_c16++;
      if (m_c4 < 15) m_c4++;
    end
  endtask

  // One clock: drive, push expectation, clock, pop and compare.
  task automatic step(input logic e, input logic ce, input logic fl, input logic clr);
    exp_t x;
    en = e; chain_en = ce; flip = fl; clr_cnt = clr;
    #1;
    model_step(e, din, clr);
    x.st = 2'(m_st); x.lk = (m_st == 2); x.pl = m_pl;
    x.c16 = 16'(m_c16); x.c4 = 4'(m_c4);
    sb.push_back(x);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      x = sb.pop_front();
      chk("state", state_o, x.st);
      chk("locked", locked, x.lk);
      chk("pulse", err_pulse, x.pl);
      chk("count", err_count, x.c16);
      chk("locked4", locked4, x.lk);
      chk("pulse4", err_pulse4, x.pl);
      chk("count4", err_count4, x.c4);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; chain_en = 1'b0; flip = 1'b0; clr_cnt = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_state", state_o, 0);
    chk("rst_locked", locked, 0);
    chk("rst_pulse", err_pulse, 0);
    chk("rst_count", err_count, 0);
    rst_n = 1'b1;
  endtask

  task automatic prime();
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int lock_at, pulses, minlk, fall_at, rise_at, hi, waited;
    #1;
    // 1: acquisition and clean run
    do_reset();
    prime();
    lock_at = 0;
    for (int i = 1; i <= 1000; i++) begin
      step(1, 1, 0, 0);
      if (lock_at == 0 && locked) lock_at = i;
    end
    chk("t1_lock_at", lock_at, 15);
    chk("t1_count", err_count, 0);

    // 2: single flipped bit
    pulses = 0; minlk = 1;
    step(1, 1, 1, 0);
    if (err_pulse) pulses++;
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 0);
      if (err_pulse) pulses++;
      if (!locked) minlk = 0;
    end
    chk("t2_pulses", pulses, 1);
    chk("t2_count", err_count, 1);
    chk("t2_locked", minlk, 1);

    // 3: four consecutive flips -> loss, then relock
    step(1, 1, 0, 1);
    chk("t3_clr", err_count, 0);
    fall_at = 0; rise_at = 0;
    for (int j = 1; j <= 40; j++) begin
      step(1, 1, (j <= 4), 0);
      if (fall_at == 0 && !locked) fall_at = j;
      else if (fall_at != 0 && rise_at == 0 && locked) rise_at = j;
    end
    chk("t3_fall_at", fall_at, 7);
    chk("t3_rise_at", rise_at, 22);
    chk("t3_count", err_count, 4);

    // 4: all-zero input never leaves HUNT
    do_reset();
    zero_mode = 1'b1;
    repeat (50) step(1, 1, 0, 0);
    chk("t4_state", state_o, 0);
    chk("t4_locked", locked, 0);
    chk("t4_count", err_count, 0);
    zero_mode = 1'b0;

    // 5: en toggling every cycle
    do_reset();
    prime();
    hi = 0; lock_at = 0;
    for (int i = 0; i < 80; i++) begin
      step((i % 2) == 0, (i % 2) == 0, 0, 0);
      if ((i % 2) == 0) hi++;
      else chk("t5_pulse_en0", err_pulse, 0);
      if (lock_at == 0 && locked) lock_at = hi;
    end
    chk("t5_lock_hi", lock_at, 15);
    chk("t5_count", err_count, 0);

    // 6: saturation, clear vs error, async reset
    for (int k = 0; k < 20; k++) begin
      step(1, 1, 1, 0);
      repeat (6) step(1, 1, 0, 0);
    end
    chk("t6_sat4", err_count4, 15);
    chk("t6_cnt16", err_count, 20);
    chk("t6_locked", locked, 1);

    step(1, 1, 1, 0);
    waited = 0;
    while (fm[2] !== 1'b1 && waited < 5) begin
      step(1, 1, 0, 0);
      waited++;
    end
    chk("t6_flip_reach", fm[2], 1);
    step(1, 1, 0, 1);
    chk("t6_clr_pulse", err_pulse, 1);
    chk("t6_clr_cnt", err_count, 0);
    chk("t6_clr_cnt4", err_count4, 0);

    step(1, 1, 1, 0);
    repeat (3) step(1, 1, 0, 0);
    chk("t6_pre_rst_pulse", err_pulse, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_locked", locked, 0);
    chk("t6_arst_pulse", err_pulse, 0);
    chk("t6_arst_count", err_count, 0);
    chk("t6_arst_state", state_o, 0);
    chk("t6_arst_count4", err_count4, 0);
    model_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
